// File: rtl/imem_loader.sv
// Byte-stream program loader: writes words into instruction memory and holds the core in reset until a clean load.
// Optional trailer checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_data_i,
    output logic                  byte_ready_o,
    output logic                  imem_we_o,
    output logic [ADDR_WIDTH-1:0] imem_waddr_o,
    output logic [DATA_WIDTH-1:0] imem_wdata_o,
    output logic                  core_reset_o,
    output logic                  done_o,
    output logic                  error_o
);
    localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);
    localparam int IW    = ADDR_WIDTH - 2;

    typedef enum logic [3:0] {
        S_IDLE, S_HDR0, S_HDR1, S_CHECK, S_DATA, S_WRITE, S_DONE, S_ERROR
`ifdef IMEM_LOADER_CHECKSUM_EN
        , S_CSUM
`endif
    } state_e;

    state_e                state_q, state_d;
    logic [15:0]           len_q;
    logic [IW-1:0]         word_idx_q;
    logic [1:0]            byte_cnt_q;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic                  ready_q, we_q, core_reset_q, done_q, error_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  xfer, last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            xor_q;
`endif

    assign xfer      = byte_valid_i && ready_q;
    assign last_word = int'(word_idx_q) == int'(len_q) - 1;

    always_comb begin
        word_d = word_q;
        word_d[{byte_cnt_q, 3'b000} +: 8] = byte_data_i;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_HDR0;
            S_HDR0:  if (xfer) state_d = S_HDR1;
            S_HDR1:  if (xfer) state_d = S_CHECK;
            S_CHECK: begin
                if (len_q == 16'd0)            state_d = S_DONE;
                else if (int'(len_q) > DEPTH)  state_d = S_ERROR;
                else                           state_d = S_DATA;
            end
            S_DATA:  if (xfer && byte_cnt_q == 2'd3) state_d = S_WRITE;
            S_WRITE: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_d = last_word ? S_CSUM : S_DATA;
`else
                state_d = last_word ? S_DONE : S_DATA;
`endif
            end
            S_DONE:  if (start_i) state_d = S_HDR0;
            S_ERROR: if (start_i) state_d = S_HDR0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM:  if (xfer) state_d = (byte_data_i == xor_q) ? S_DONE : S_ERROR;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            word_idx_q   <= '0;
            byte_cnt_q   <= '0;
            word_q       <= '0;
            ready_q      <= 1'b0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            ready_q      <= (state_d == S_HDR0) || (state_d == S_HDR1) || (state_d == S_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                            || (state_d == S_CSUM)
`endif
                            ;
            we_q         <= state_d == S_WRITE;
            done_q       <= state_d == S_DONE;
            error_q      <= state_d == S_ERROR;
            core_reset_q <= state_d != S_DONE;

            if (state_q == S_HDR0 && xfer) len_q[7:0]  <= byte_data_i;
            if (state_q == S_HDR1 && xfer) len_q[15:8] <= byte_data_i;

            if (state_q == S_CHECK) begin
                word_idx_q <= '0;
                byte_cnt_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                xor_q      <= '0;
`endif
            end

            if (state_q == S_DATA && xfer) begin
                word_q     <= word_d;
                byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                xor_q      <= xor_q ^ byte_data_i;
`endif
                if (byte_cnt_q == 2'd3) begin
                    waddr_q <= {word_idx_q, 2'b00};
                    wdata_q <= word_d;
                end
            end

            if (state_q == S_WRITE && !last_word) word_idx_q <= word_idx_q + 1'b1;
        end
    end

    assign byte_ready_o = ready_q;
    assign imem_we_o    = we_q;
    assign imem_waddr_o = waddr_q;
    assign imem_wdata_o = wdata_q;
    assign core_reset_o = core_reset_q;
    assign done_o       = done_q;
    assign error_o      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as bytes are driven and popped on imem_we_o.
module tb_imem_loader;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b1;
    logic          start_i = 1'b0;
    logic          byte_valid_i = 1'b0;
    logic [7:0]    byte_data_i = '0;
    logic          byte_ready_o, imem_we_o, core_reset_o, done_o, error_o;
    logic [AW-1:0] imem_waddr_o;
    logic [DW-1:0] imem_wdata_o;

    int checks = 0;
    int errors = 0;
    logic [AW+DW-1:0] sb[$];
    logic [31:0]      wq[$];

    imem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i),
        .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i), .byte_ready_o(byte_ready_o),
        .imem_we_o(imem_we_o), .imem_waddr_o(imem_waddr_o), .imem_wdata_o(imem_wdata_o),
        .core_reset_o(core_reset_o), .done_o(done_o), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    // Write monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk_i) begin
        if (!reset_i && imem_we_o) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%h data=%h, required no write", imem_waddr_o, imem_wdata_o);
            end else begin
                logic [AW+DW-1:0] exp;
                exp = sb.pop_front();
                if ({imem_waddr_o, imem_wdata_o} !== exp) begin
                    errors++;
                    $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                             imem_waddr_o, imem_wdata_o, exp[AW+DW-1:DW], exp[DW-1:0]);
                end
            end
        end
    end

    task automatic start_pulse();
        @(posedge clk_i); #1 start_i = 1'b1;
        @(posedge clk_i); #1 start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        if (gap > 0) begin
            byte_valid_i = 1'b0;
            repeat (gap) @(posedge clk_i);
            #1;
        end
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        n = 0;
        while (n < 100) begin
            @(negedge clk_i);
            if (byte_ready_o) break;
            n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL byte_accept: byte %h not accepted, required acceptance", b);
            byte_valid_i = 1'b0;
        end else begin
            @(posedge clk_i); #1;
        end
    endtask

    task automatic load(input logic [15:0] n, input logic [31:0] w[$], input int gap);
        logic [7:0] x;
        x = 8'h00;
        send_byte(n[7:0], gap);
        send_byte(n[15:8], gap);
        foreach (w[i]) begin
            sb.push_back({AW'(i * 4), w[i]});
            for (int k = 0; k < 4; k++) begin
                logic [7:0] b;
                b = w[i][8*k +: 8];
                x ^= b;
                send_byte(b, gap);
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (w.size() > 0) send_byte(x, gap);
`endif
        byte_valid_i = 1'b0;
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (n < 500 && !(done_o || error_o)) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 500) begin
            checks++; errors++;
            $display("FAIL wait_end: no done/error within bound, required termination");
        end
    endtask

    task automatic check_done(input string name);
        checks++;
        if ({done_o, error_o, core_reset_o} !== 3'b100) begin
            errors++;
            $display("FAIL %s: done/error/core_reset=%b%b%b, required 100", name, done_o, error_o, core_reset_o);
        end
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL %s_writes: %0d writes missing, required 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if ({byte_ready_o, imem_we_o, imem_waddr_o, imem_wdata_o, core_reset_o, done_o, error_o} !==
            {1'b0, 1'b0, {AW{1'b0}}, {DW{1'b0}}, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b we=%b addr=%h data=%h crst=%b done=%b err=%b, required 0 0 0 0 1 0 0",
                     byte_ready_o, imem_we_o, imem_waddr_o, imem_wdata_o, core_reset_o, done_o, error_o);
        end
        reset_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if (byte_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready: got %b, required 0", byte_ready_o);
        end
    endtask

    task automatic test_nominal();
        wq = {32'h00500513, 32'h00A00593};
        start_pulse();
        load(16'd2, wq, 0);
        wait_end();
        check_done("nominal");
    endtask

    task automatic test_gaps();
        wq = {32'h00500513, 32'h00A00593};
        start_pulse();
        checks++;
        if ({core_reset_o, done_o} !== 2'b10) begin
            errors++;
            $display("FAIL restart_from_done: crst/done=%b%b, required 10", core_reset_o, done_o);
        end
        load(16'd2, wq, 3);
        wait_end();
        check_done("gaps");
    endtask

    task automatic test_capacity();
        wq.delete();
        for (int i = 0; i < 8; i++) wq.push_back($urandom);
        start_pulse();
        load(16'd8, wq, 0);
        wait_end();
        check_done("cap8");
        checks++;
        if (imem_waddr_o !== 5'h1C) begin
            errors++;
            $display("FAIL cap8_last_addr: got %h, required 1c", imem_waddr_o);
        end
        wq.delete();
        start_pulse();
        load(16'd9, wq, 0);
        wait_end();
        repeat (3) @(negedge clk_i);
        checks++;
        if ({error_o, done_o, core_reset_o, byte_ready_o} !== 4'b1010) begin
            errors++;
            $display("FAIL cap9_error: err/done/crst/ready=%b%b%b%b, required 1010",
                     error_o, done_o, core_reset_o, byte_ready_o);
        end
    endtask

    task automatic test_zero_reload();
        wq.delete();
        start_pulse();
        checks++;
        if (error_o !== 1'b0) begin
            errors++;
            $display("FAIL error_clear: got %b, required 0", error_o);
        end
        load(16'd0, wq, 0);
        wait_end();
        check_done("zero_len");
        start_pulse();
        checks++;
        if ({core_reset_o, done_o} !== 2'b10) begin
            errors++;
            $display("FAIL reload_reset: crst/done=%b%b, required 10", core_reset_o, done_o);
        end
        wq = {32'hDEADBEEF};
        load(16'd1, wq, 0);
        wait_end();
        check_done("reload");
    endtask

    task automatic test_async_reset();
        start_pulse();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        sb.push_back({5'h00, 32'h44332211});
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
        send_byte(8'h55, 0); send_byte(8'h66, 0);
        byte_valid_i = 1'b0;
        #2 reset_i = 1'b1;
        #1;
        checks++;
        if ({byte_ready_o, imem_we_o, imem_waddr_o, imem_wdata_o, core_reset_o, done_o, error_o} !==
            {1'b0, 1'b0, {AW{1'b0}}, {DW{1'b0}}, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: ready=%b we=%b addr=%h data=%h crst=%b done=%b err=%b, required 0 0 0 0 1 0 0",
                     byte_ready_o, imem_we_o, imem_waddr_o, imem_wdata_o, core_reset_o, done_o, error_o);
        end
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL async_reset_word0: %0d writes missing, required 0", sb.size());
        end
        @(posedge clk_i); #1 reset_i = 1'b0;
        wq = {32'h00500513, 32'h00A00593};
        start_pulse();
        load(16'd2, wq, 0);
        wait_end();
        check_done("after_reset");
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] s[$];
        s = {8'h01, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h46};
        start_pulse();
        sb.push_back({5'h00, 32'h00500513});
        foreach (s[i]) send_byte(s[i], 0);
        byte_valid_i = 1'b0;
        wait_end();
        check_done("csum_good");
        s[6] = 8'h47;
        start_pulse();
        sb.push_back({5'h00, 32'h00500513});
        foreach (s[i]) send_byte(s[i], 0);
        byte_valid_i = 1'b0;
        wait_end();
        checks++;
        if ({error_o, done_o, core_reset_o} !== 3'b101) begin
            errors++;
            $display("FAIL csum_bad: err/done/crst=%b%b%b, required 101", error_o, done_o, core_reset_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        test_gaps();
        test_capacity();
        test_zero_reload();
        test_async_reset();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        repeat (3) @(posedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side counterpart to the core's instruction fetch path: receives a program as a byte stream and writes it word-by-word into instruction memory.
- Holds the core in reset while loading and releases it only when a load completes cleanly.
- Sits between a byte source (UART receiver or bench) and the instruction memory write port, alongside core_top.

Parameters:
- DATA_WIDTH, 32, instruction word width; only 32 is supported (4 bytes per word).
- ADDR_WIDTH, 5, instruction memory byte-address width; capacity DEPTH = 2**(ADDR_WIDTH-2) words (8 by default).

Ports:
- clk_i  input  1  system clock.
- reset_i  input  1  asynchronous, active-high reset.
- start_i  input  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- byte_valid_i  input  1  source has a byte on byte_data_i.
- byte_data_i  input  8  stream byte.
- byte_ready_o  output  1  loader accepts a byte; a transfer occurs when byte_valid_i && byte_ready_o at the clock edge.
- imem_we_o  output  1  instruction memory write strobe, one cycle per word.
- imem_waddr_o  output  ADDR_WIDTH  byte address of the word being written (word_idx*4).
- imem_wdata_o  output  DATA_WIDTH  assembled word.
- core_reset_o  output  1  reset to core_top; high except in DONE.
- done_o  output  1  load completed successfully (level).
- error_o  output  1  load rejected (level).

Behaviour:
- Reset (asynchronous, reset_i high): state=IDLE, all counters and the length register cleared.
  - Output values: byte_ready_o=0, imem_we_o=0, imem_waddr_o=0, imem_wdata_o=0, core_reset_o=1, done_o=0, error_o=0.
- Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then N*4 data bytes, each word little-endian (first byte -> bits [7:0]).
- States:
  - IDLE: byte_ready_o=0. start_i -> HDR0.
  - HDR0: byte_ready_o=1. On transfer, len[7:0]=byte -> HDR1.
  - HDR1: byte_ready_o=1. On transfer, len[15:8]=byte -> CHECK.
  - CHECK (1 cycle, byte_ready_o=0):
    - N==0 -> DONE with no writes.
    - N>DEPTH -> ERROR.
    - Otherwise word_idx=0, byte_cnt=0 -> DATA.
  - DATA: byte_ready_o=1. Each transfer places the byte at lane byte_cnt and increments byte_cnt (2-bit, wraps). The transfer with byte_cnt==3 -> WRITE.
  - WRITE (1 cycle, byte_ready_o=0): imem_we_o=1, imem_waddr_o=word_idx*4, imem_wdata_o=assembled word.
    - word_idx==N-1 -> DONE (or CSUM with CHECKSUM_EN).
    - Otherwise word_idx++ -> DATA.
  - DONE: core_reset_o=0, done_o=1, byte_ready_o=0. start_i -> HDR0; core_reset_o and done_o return to 1 and 0 in the same cycle the state changes.
  - ERROR: error_o=1, core_reset_o=1, byte_ready_o=0. start_i -> HDR0 and clears error_o.
- Timing and latency:
  - imem_we_o asserts exactly one cycle after the 4th byte of a word is accepted.
  - DONE is entered the cycle after the last WRITE.
- Held outputs: imem_waddr_o and imem_wdata_o hold their last values outside WRITE. imem_we_o is 0 outside WRITE.
- Handshake: byte_valid_i gaps are tolerated in any accepting state with no state change; bytes offered while byte_ready_o=0 are not consumed.
- Ignored stimulus: start_i is ignored in HDR0/HDR1/CHECK/DATA/WRITE.
- Reset mid-load: reset_i aborts to IDLE immediately; words already written remain in memory; core_reset_o stays 1.
- Address wrap: none is possible, since N<=DEPTH is enforced in CHECK.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE, enter CSUM (byte_ready_o=1) and accept one trailer byte.
  - If the trailer equals the XOR of all N*4 data bytes -> DONE; otherwise -> ERROR, and the core stays in reset.
  - The XOR accumulator clears in CHECK.
  - For N==0 the trailer is not expected; go to DONE directly.
- Undefined: no CSUM state; the stream ends after the data bytes.

Test Plan:
- Nominal two-word load.
  - Stimulus: start_i, bytes 02 00 13 05 50 00 93 05 A0 00, valid held high.
  - Response: writes 0x00500513 @0 and 0x00A00593 @4, one cycle each; done_o=1; core_reset_o=0; error_o=0.
- Backpressure and gaps.
  - Stimulus: same stream with byte_valid_i low 3 cycles between every byte.
  - Response: identical writes and data; no extra or lost bytes.
- Capacity boundary.
  - N=8 with 32 bytes -> last write @0x1C, then DONE.
  - N=9 (09 00) -> ERROR after CHECK, no writes, byte_ready_o=0.
- Zero length and reload.
  - Stimulus: N=0, then start_i in DONE, then a 1-word load.
  - Response: DONE with no writes first; on start_i, core_reset_o reasserts; then one write @0 and DONE.
- Asynchronous reset mid-DATA.
  - Stimulus: assert reset_i after the 2nd byte of word 1.
  - Response: outputs reach reset values without a clock edge; state IDLE; a subsequent start_i and full load succeed.
- Checksum (with IMEM_LOADER_CHECKSUM_EN).
  - N=1, data 13 05 50 00, trailer 0x46 -> DONE.
  - Trailer 0x47 -> ERROR, core_reset_o=1.
